// File: rtl/baseband_agc.sv
// baseband_agc: automatic gain control between the AM detector and the DAC driver.
// Three-stage pipelined multiply of the signed baseband sample by an unsigned
// Q8.8 gain, with saturation. The gain is either set manually or steered by an
// attack/hold/release state machine that watches the output magnitude.
//
// Ports:
//   aclk         sample-domain clock
//   reset        synchronous, active-high reset
//   i_valid      input sample strobe
//   baseband     signed 16-bit detector sample
//   agc_en       1 = automatic gain, 0 = manual gain
//   manual_gain  Q8.8 gain used while agc_en = 0 (clamped to the gain range)
//   o_valid      output sample strobe (3 cycles after i_valid)
//   audio        signed, saturated output sample
//   gain         current gain register (Q8.8)
//   clip         high with o_valid when the sample saturated
//   state        0 = RELEASE, 1 = HOLD, 2 = MANUAL
module baseband_agc #(
  parameter logic [15:0] GAIN_INIT    = 16'h0100,
  parameter logic [15:0] GAIN_MIN     = 16'h0010,
  parameter logic [15:0] GAIN_MAX     = 16'h4000,
  parameter int unsigned TARGET       = 12000,
  parameter int unsigned ATTACK_SHIFT = 4,
  parameter int unsigned HOLD_SAMPLES = 16000,
  parameter int unsigned RELEASE_DIV  = 256
) (
  input  logic               aclk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic signed [15:0] baseband,
  input  logic               agc_en,
  input  logic        [15:0] manual_gain,
  output logic               o_valid,
  output logic signed [15:0] audio,
  output logic        [15:0] gain,
  output logic               clip,
  output logic         [1:0] state
);

  localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam int unsigned REL_W  = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_HOLD    = 2'd1,
    ST_MANUAL  = 2'd2
  } agc_state_e;

  // Pipeline registers
  logic               v1, v2;
  logic signed [15:0] x1;
  logic        [15:0] g1;
  logic signed [32:0] p2;
  logic        [24:0] mag3;

  // Gain control registers
  agc_state_e         state_q, state_d;
  logic        [15:0] gain_d;
  logic  [HOLD_W-1:0] hold_cnt, hold_d;
  logic   [REL_W-1:0] rel_cnt, rel_d;

  // Combinational datapath helpers
  logic signed [32:0] p_c;
  logic signed [24:0] s_c;
  logic               ovf_c;
  logic signed [15:0] sat_c;
  logic        [24:0] mag_c;

  // Gain is zero-extended so the multiply stays signed without reinterpreting bit 15.
  assign p_c   = 33'(x1) * 33'($signed({1'b0, g1}));
  assign s_c   = 25'(p2 >>> 8);
  assign ovf_c = (s_c[24:15] != {10{s_c[24]}});
  assign sat_c = ovf_c ? (s_c[24] ? 16'sh8000 : 16'sh7FFF) : s_c[15:0];
  // 25 bits hold |-32768 * 0xFFFF >> 8| without overflow.
  assign mag_c = s_c[24] ? (25'd0 - 25'(s_c)) : 25'(s_c);

  // Three-stage multiply/saturate pipeline; reset drops in-flight samples.
  always_ff @(posedge aclk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
      x1      <= '0;
      g1      <= '0;
      p2      <= '0;
      audio   <= '0;
      clip    <= 1'b0;
      mag3    <= '0;
    end else begin
      v1      <= i_valid;
      v2      <= v1;
      o_valid <= v2;
      clip    <= v2 & ovf_c;
      if (i_valid) begin
        x1 <= baseband;
        g1 <= gain;
      end
      if (v1) begin
        p2 <= p_c;
      end
      if (v2) begin
        audio <= sat_c;
        mag3  <= mag_c;
      end
    end
  end

  // Gain arithmetic candidates
  logic        above_c;
  logic [15:0] dec_c;
  logic [16:0] diff_c;
  logic [15:0] attack_gain_c;
  logic [15:0] inc_gain_c;
  logic [15:0] manual_clamp_c;

  always_comb begin
    above_c = (mag3 > 25'(TARGET));
    dec_c   = gain >> ATTACK_SHIFT;
    if (dec_c == 16'd0) begin
      dec_c = 16'd1;
    end
    diff_c = {1'b0, gain} - {1'b0, dec_c};
    if (diff_c[16] || (diff_c[15:0] < GAIN_MIN)) begin
      attack_gain_c = GAIN_MIN;
    end else begin
      attack_gain_c = diff_c[15:0];
    end
    inc_gain_c = (gain >= GAIN_MAX) ? GAIN_MAX : (gain + 16'd1);
    if (manual_gain < GAIN_MIN) begin
      manual_clamp_c = GAIN_MIN;
    end else if (manual_gain > GAIN_MAX) begin
      manual_clamp_c = GAIN_MAX;
    end else begin
      manual_clamp_c = manual_gain;
    end
  end

  // State and gain registers
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q  <= ST_RELEASE;
      gain     <= GAIN_INIT;
      hold_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      gain     <= gain_d;
      hold_cnt <= hold_d;
      rel_cnt  <= rel_d;
    end
  end

  // Next-state: manual override first, then attack/hold/release on each output sample.
  always_comb begin
    state_d = state_q;
    gain_d  = gain;
    hold_d  = hold_cnt;
    rel_d   = rel_cnt;
    if (!agc_en) begin
      state_d = ST_MANUAL;
      gain_d  = manual_clamp_c;
      hold_d  = '0;
      rel_d   = '0;
    end else begin
      unique case (state_q)
        ST_MANUAL: begin
          // Leaving manual mode keeps the current gain and restarts release timing.
          state_d = ST_RELEASE;
          rel_d   = '0;
        end
        ST_RELEASE: begin
          if (o_valid) begin
            if (above_c) begin
              gain_d  = attack_gain_c;
              hold_d  = HOLD_W'(HOLD_SAMPLES);
              state_d = ST_HOLD;
            end else if (rel_cnt == REL_W'(RELEASE_DIV - 1)) begin
              gain_d = inc_gain_c;
              rel_d  = '0;
            end else begin
              rel_d = rel_cnt + REL_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (o_valid) begin
            if (above_c) begin
              gain_d = attack_gain_c;
              hold_d = HOLD_W'(HOLD_SAMPLES);
            end else if (hold_cnt <= HOLD_W'(1)) begin
              hold_d  = '0;
              state_d = ST_RELEASE;
              rel_d   = '0;
            end else begin
              hold_d = hold_cnt - HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_RELEASE;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_baseband_agc.sv
// tb_baseband_agc: directed, self-checking bench for baseband_agc.
// Covers reset values, manual pass-through, truncation, saturation, manual
// clamping, attack threshold, repeated attack, hold length, release stepping,
// upper clamp, streaming latency and mid-stream reset.
module tb_baseband_agc;

  logic               aclk = 1'b0;
  logic               reset;
  logic               i_valid;
  logic signed [15:0] baseband;
  logic               agc_en;
  logic        [15:0] manual_gain;
  logic               o_valid;
  logic signed [15:0] audio;
  logic        [15:0] gain;
  logic               clip;
  logic         [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] ra;
  logic               rc;
  logic signed [15:0] exp_v;

  // Expected gain after each successive attack with baseband = 20000 from unity.
  logic [15:0] att_exp [9] = '{16'h00F0, 16'h00E1, 16'h00D3, 16'h00C6, 16'h00BA,
                               16'h00AF, 16'h00A5, 16'h009B, 16'h0092};

  baseband_agc dut (
    .aclk        (aclk),
    .reset       (reset),
    .i_valid     (i_valid),
    .baseband    (baseband),
    .agc_en      (agc_en),
    .manual_gain (manual_gain),
    .o_valid     (o_valid),
    .audio       (audio),
    .gain        (gain),
    .clip        (clip),
    .state       (state)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One isolated sample; returns the output and checks the 3-cycle latency.
  task automatic send_one(input logic signed [15:0] x,
                          output logic signed [15:0] a, output logic c);
    int lat;
    lat = -1;
    a   = 'x;
    c   = 1'bx;
    @(negedge aclk);
    baseband = x;
    i_valid  = 1'b1;
    @(negedge aclk);
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (o_valid === 1'b1) begin
        lat = k;
        a   = audio;
        c   = clip;
        break;
      end
      @(negedge aclk);
    end
    chk("latency", 16'(lat), 16'd2);
    @(negedge aclk);
  endtask

  // Back-to-back zero samples, then drain the pipeline.
  task automatic stream_zeros(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      baseband = 16'sd0;
      i_valid  = 1'b1;
    end
    @(negedge aclk);
    i_valid = 1'b0;
    repeat (4) @(negedge aclk);
  endtask

  initial begin
    reset       = 1'b1;
    i_valid     = 1'b0;
    baseband    = 16'sd0;
    agc_en      = 1'b0;
    manual_gain = 16'h0100;
    repeat (2) @(negedge aclk);
    chk("rst_o_valid", {15'd0, o_valid}, 16'd0);
    chk("rst_audio", audio, 16'h0000);
    chk("rst_clip", {15'd0, clip}, 16'd0);
    chk("rst_gain", gain, 16'h0100);
    chk("rst_state", {14'd0, state}, 16'd0);
    reset = 1'b0;
    @(negedge aclk);
    chk("manual_state", {14'd0, state}, 16'd2);

    // Unity pass-through, single pulse
    send_one(16'sd1000, ra, rc);
    chk("unity_audio", ra, 16'd1000);
    chk("unity_clip", {15'd0, rc}, 16'd0);
    chk("unity_single_pulse", {15'd0, o_valid}, 16'd0);

    // Arithmetic shift truncates toward minus infinity
    manual_gain = 16'h0080;
    repeat (2) @(negedge aclk);
    send_one(-16'sd3, ra, rc);
    chk("trunc_neg", ra, 16'hFFFE);
    send_one(16'sd3, ra, rc);
    chk("trunc_pos", ra, 16'h0001);

    // Saturation at x4
    manual_gain = 16'h0400;
    repeat (2) @(negedge aclk);
    send_one(16'sd10000, ra, rc);
    chk("sat_pos_audio", ra, 16'h7FFF);
    chk("sat_pos_clip", {15'd0, rc}, 16'd1);
    send_one(-16'sd32768, ra, rc);
    chk("sat_neg_audio", ra, 16'h8000);
    chk("sat_neg_clip", {15'd0, rc}, 16'd1);
    send_one(-16'sd8192, ra, rc);
    chk("edge_neg_audio", ra, 16'h8000);
    chk("edge_neg_clip", {15'd0, rc}, 16'd0);
    send_one(16'sd8191, ra, rc);
    chk("edge_pos_audio", ra, 16'd32764);
    chk("edge_pos_clip", {15'd0, rc}, 16'd0);

    // Manual clamp
    manual_gain = 16'h0000;
    repeat (2) @(negedge aclk);
    chk("clamp_low", gain, 16'h0010);
    manual_gain = 16'hFFFF;
    repeat (2) @(negedge aclk);
    chk("clamp_high", gain, 16'h4000);
    chk("clamp_state", {14'd0, state}, 16'd2);

    // Threshold: m == TARGET holds, m > TARGET attacks
    manual_gain = 16'h0100;
    repeat (2) @(negedge aclk);
    agc_en = 1'b1;
    @(negedge aclk);
    chk("agc_on_state", {14'd0, state}, 16'd0);
    chk("agc_on_gain", gain, 16'h0100);
    send_one(16'sd12000, ra, rc);
    chk("eq_target_audio", ra, 16'd12000);
    chk("eq_target_gain", gain, 16'h0100);
    chk("eq_target_state", {14'd0, state}, 16'd0);
    send_one(16'sd12001, ra, rc);
    chk("over_target_gain", gain, 16'h00F0);
    chk("over_target_state", {14'd0, state}, 16'd1);

    // Repeated attack from unity
    agc_en      = 1'b0;
    manual_gain = 16'h0100;
    repeat (2) @(negedge aclk);
    agc_en = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 9; i++) begin
      send_one(16'sd20000, ra, rc);
      chk("attack_gain", gain, att_exp[i]);
      chk("attack_state", {14'd0, state}, 16'd1);
    end

    // Hold for exactly 16000 samples, then release one step per 256 samples
    stream_zeros(15999);
    chk("hold_state", {14'd0, state}, 16'd1);
    chk("hold_gain", gain, 16'h0092);
    stream_zeros(1);
    chk("hold_end_state", {14'd0, state}, 16'd0);
    stream_zeros(255);
    chk("rel_255_gain", gain, 16'h0092);
    stream_zeros(1);
    chk("rel_256_gain", gain, 16'h0093);
    chk("rel_state", {14'd0, state}, 16'd0);

    // Release stops at GAIN_MAX
    agc_en      = 1'b0;
    manual_gain = 16'h3FFE;
    repeat (2) @(negedge aclk);
    agc_en = 1'b1;
    @(negedge aclk);
    stream_zeros(511);
    chk("rel_top_511", gain, 16'h3FFF);
    stream_zeros(1);
    chk("rel_top_512", gain, 16'h4000);
    stream_zeros(256);
    chk("rel_top_clamp", gain, 16'h4000);
    chk("rel_top_state", {14'd0, state}, 16'd0);

    // Streaming ramp at x2, then reset mid-stream
    agc_en      = 1'b0;
    manual_gain = 16'h0200;
    repeat (2) @(negedge aclk);
    for (int t = 0; t < 24; t++) begin
      @(negedge aclk);
      if (t >= 3) begin
        exp_v = 16'((t - 3) * 2000 - 20000);
        chk("ramp_valid", {15'd0, o_valid}, 16'd1);
        chk("ramp_audio", audio, exp_v);
      end else begin
        chk("ramp_idle", {15'd0, o_valid}, 16'd0);
      end
      baseband = 16'(t * 1000 - 10000);
      i_valid  = 1'b1;
    end
    @(negedge aclk);
    reset = 1'b1;
    @(negedge aclk);
    chk("midrst_o_valid", {15'd0, o_valid}, 16'd0);
    chk("midrst_gain", gain, 16'h0100);
    chk("midrst_state", {14'd0, state}, 16'd0);
    reset   = 1'b0;
    i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("post_rst_quiet", {15'd0, o_valid}, 16'd0);
    end
    send_one(16'sd500, ra, rc);
    chk("post_rst_audio", ra, 16'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
